// File: rtl/blackjack_round_ctrl_pkg.sv
// Shared types and constants for the blackjack round sequencer.
// Holds the FSM state enum, the outcome codes and the card-rank decoder.
package blackjack_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEAL_P1,
        ST_DEAL_D1,
        ST_DEAL_P2,
        ST_PLAYER_WAIT,
        ST_PLAYER_DRAW,
        ST_DEALER_DRAW,
        ST_DEALER_CHK,
        ST_RESOLVE,
        ST_DONE
    } bj_state_e;

    typedef enum logic [1:0] {
        OUT_NONE = 2'd0,
        OUT_WIN  = 2'd1,
        OUT_LOSS = 2'd2,
        OUT_PUSH = 2'd3
    } bj_outcome_e;

    localparam logic [4:0] BJ_LIMIT     = 5'd21;
    localparam logic [4:0] DEALER_STAND = 5'd17;

    // Ranks 9..15 all score 10; the ace enters a hand as 11 and may be lowered later.
    function automatic logic [3:0] card_value(input logic [3:0] idx);
        if (idx == 4'd0)       return 4'd11;
        else if (idx <= 4'd8)  return idx + 4'd1;
        else                   return 4'd10;
    endfunction

endpackage

// File: rtl/blackjack_round_ctrl_if.sv
// Card source handshake: the sequencer requests, the RNG answers with a rank.
interface blackjack_round_ctrl_if;
    logic       card_req;
    logic       card_vld;
    logic [3:0] card_idx;

    modport master (output card_req, input card_vld, input card_idx);
    modport slave  (input card_req, output card_vld, output card_idx);
endinterface

// File: rtl/blackjack_round_ctrl_hand_accum.sv
// One hand's running total with soft-ace tracking.
// total_nxt is the value the hand takes if the current card is added.
module hand_accum
    import blackjack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_en,
    input  logic [3:0] card_idx,
    output logic [4:0] total,
    output logic [4:0] total_nxt,
    output logic [2:0] soft_aces
);

    logic [5:0] sum;
    logic [2:0] aces;
    logic       unused_carry;

    // A hand never exceeds 31 after lowering, so the carry bit is only scratch.
    always_comb begin
        sum  = {1'b0, total} + {2'b00, card_value(card_idx)};
        aces = soft_aces + {2'b00, (card_idx == 4'd0)};
        if (sum > {1'b0, BJ_LIMIT} && aces != 3'd0) begin
            sum  = sum - 6'd10;
            aces = aces - 3'd1;
        end
    end

    assign total_nxt    = sum[4:0];
    assign unused_carry = sum[5];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            total     <= '0;
            soft_aces <= '0;
        end else if (add_en) begin
            total     <= sum[4:0];
            soft_aces <= aces;
        end
    end

endmodule

// File: rtl/blackjack_round_ctrl.sv
// Blackjack round sequencer: opening deal, player hit/stay, dealer draw-to-17,
// resolution and saturating win/loss/push tallies.
module blackjack_round_ctrl
    import blackjack_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                    clk_200Hz,
    input  logic                    btnR,
    input  logic                    start,
    input  logic                    hit,
    input  logic                    stay,
    blackjack_round_ctrl_if.master  card,
    output logic [4:0]              player_total,
    output logic [4:0]              dealer_total,
    output logic [1:0]              outcome,
    output logic                    round_done,
    output logic                    busy,
    output logic [CNT_W-1:0]        wins,
    output logic [CNT_W-1:0]        losses,
    output logic [CNT_W-1:0]        pushes
);

    bj_state_e   state, state_n;
    bj_outcome_e res;
    logic        xfer, clr, p_add, d_add, req_n, dealer_stand;
    logic [4:0]  p_nxt, d_nxt;
    logic [2:0]  p_soft, d_soft;
    logic        unused_soft;

    hand_accum u_player (
        .clk(clk_200Hz), .rst(btnR), .clear(clr), .add_en(p_add), .card_idx(card.card_idx),
        .total(player_total), .total_nxt(p_nxt), .soft_aces(p_soft)
    );

    hand_accum u_dealer (
        .clk(clk_200Hz), .rst(btnR), .clear(clr), .add_en(d_add), .card_idx(card.card_idx),
        .total(dealer_total), .total_nxt(d_nxt), .soft_aces(d_soft)
    );

    assign unused_soft = ^{p_soft, d_soft};
    assign xfer        = card.card_req && card.card_vld;
    assign busy        = !(state == ST_IDLE || state == ST_DONE);

    always_ff @(posedge clk_200Hz) begin
        if (btnR) state <= ST_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        p_add   = 1'b0;
        d_add   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: if (start) begin
                clr     = 1'b1;
                state_n = ST_DEAL_P1;
            end
            ST_DEAL_P1: if (xfer) begin
                p_add   = 1'b1;
                state_n = ST_DEAL_D1;
            end
            ST_DEAL_D1: if (xfer) begin
                d_add   = 1'b1;
                state_n = ST_DEAL_P2;
            end
            ST_DEAL_P2: if (xfer) begin
                p_add   = 1'b1;
                state_n = (p_nxt == BJ_LIMIT) ? ST_DEALER_DRAW : ST_PLAYER_WAIT;
            end
            ST_PLAYER_WAIT: begin
                if (stay)     state_n = ST_DEALER_DRAW;
                else if (hit) state_n = ST_PLAYER_DRAW;
            end
            ST_PLAYER_DRAW: if (xfer) begin
                p_add = 1'b1;
                if (p_nxt > BJ_LIMIT)       state_n = ST_RESOLVE;
                else if (p_nxt == BJ_LIMIT) state_n = ST_DEALER_DRAW;
                else                        state_n = ST_PLAYER_WAIT;
            end
            ST_DEALER_DRAW: if (xfer) begin
                d_add   = 1'b1;
                state_n = ST_DEALER_CHK;
            end
            ST_DEALER_CHK: state_n = dealer_stand ? ST_RESOLVE : ST_DEALER_DRAW;
            ST_RESOLVE:    state_n = ST_DONE;
            default:       state_n = ST_IDLE;
        endcase
    end

    assign req_n = (state_n == ST_DEAL_P1) || (state_n == ST_DEAL_D1) || (state_n == ST_DEAL_P2) ||
                   (state_n == ST_PLAYER_DRAW) || (state_n == ST_DEALER_DRAW);

    always_comb begin
        if (player_total > BJ_LIMIT)          res = OUT_LOSS;
        else if (dealer_total > BJ_LIMIT)     res = OUT_WIN;
        else if (player_total > dealer_total) res = OUT_WIN;
        else if (player_total < dealer_total) res = OUT_LOSS;
        else                                  res = OUT_PUSH;
    end

    // Stand decision is captured with the dealer's card so DEALER_CHK needs no extra compare.
    always_ff @(posedge clk_200Hz) begin
        if (btnR) begin
            card.card_req <= 1'b0;
            round_done    <= 1'b0;
            outcome       <= OUT_NONE;
            dealer_stand  <= 1'b0;
            wins          <= '0;
            losses        <= '0;
            pushes        <= '0;
        end else begin
            card.card_req <= req_n;
            round_done    <= (state == ST_RESOLVE);
            if (clr) dealer_stand <= 1'b0;
            else if (d_add) dealer_stand <= (d_nxt >= DEALER_STAND);
            if (clr) outcome <= OUT_NONE;
            else if (state == ST_RESOLVE) begin
                outcome <= res;
                case (res)
                    OUT_WIN:  if (wins   != {CNT_W{1'b1}}) wins   <= wins   + CNT_W'(1);
                    OUT_LOSS: if (losses != {CNT_W{1'b1}}) losses <= losses + CNT_W'(1);
                    OUT_PUSH: if (pushes != {CNT_W{1'b1}}) pushes <= pushes + CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blackjack_round_ctrl.sv
// Directed bench for blackjack_round_ctrl with a round-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_blackjack_round_ctrl;

    localparam int CW   = 2;
    localparam int TMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0, P_DEAL = 1, P_WAIT = 2, P_PD = 3, P_DD = 4, P_CHK = 5, P_RES = 6;

    logic          clk = 1'b0;
    logic          btnR, start, hit, stay;
    logic [4:0]    player_total, dealer_total;
    logic [1:0]    outcome;
    logic          round_done, busy;
    logic [CW-1:0] wins, losses, pushes;

    blackjack_round_ctrl_if bus();

    blackjack_round_ctrl #(.CNT_W(CW)) dut (
        .clk_200Hz(clk), .btnR(btnR), .start(start), .hit(hit), .stay(stay), .card(bus.master),
        .player_total(player_total), .dealer_total(dealer_total), .outcome(outcome),
        .round_done(round_done), .busy(busy), .wins(wins), .losses(losses), .pushes(pushes)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;
    int cq[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int ph = P_IDLE, dealt = 0;
    int praw = 0, paces = 0, draw_ = 0, daces = 0;
    int m_out = 0, m_w = 0, m_l = 0, m_p = 0;
    bit m_req = 0, m_done = 0;

    function automatic int cval(input int idx);
        if (idx == 0) return 11;
        if (idx <= 8) return idx + 1;
        return 10;
    endfunction

    // Best total: start from all aces at 11, demote aces only while over 21.
    function automatic int hval(input int raw, input int aces);
        int v = raw;
        int a = aces;
        while (v > 21 && a > 0) begin v -= 10; a--; end
        return v;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < TMAX) ? v + 1 : v;
    endfunction

    initial begin
        forever begin
            int idx, pv, dv;
            bit xf;
            @(posedge clk);
            xf  = m_req && bus.card_vld;
            idx = int'(bus.card_idx);
            if (btnR) begin
                ph = P_IDLE; dealt = 0; praw = 0; paces = 0; draw_ = 0; daces = 0;
                m_out = 0; m_w = 0; m_l = 0; m_p = 0; m_req = 0; m_done = 0;
            end else begin
                m_done = 0;
                case (ph)
                    P_IDLE: if (start) begin
                        praw = 0; paces = 0; draw_ = 0; daces = 0; m_out = 0; dealt = 0; ph = P_DEAL;
                    end
                    P_DEAL: if (xf) begin
                        if (dealt == 1) begin draw_ += cval(idx); daces += (idx == 0); end
                        else            begin praw  += cval(idx); paces += (idx == 0); end
                        dealt++;
                        if (dealt == 3) ph = (hval(praw, paces) == 21) ? P_DD : P_WAIT;
                    end
                    P_WAIT: begin
                        if (stay)     ph = P_DD;
                        else if (hit) ph = P_PD;
                    end
                    P_PD: if (xf) begin
                        praw += cval(idx); paces += (idx == 0);
                        pv = hval(praw, paces);
                        ph = (pv > 21) ? P_RES : (pv == 21) ? P_DD : P_WAIT;
                    end
                    P_DD: if (xf) begin
                        draw_ += cval(idx); daces += (idx == 0); ph = P_CHK;
                    end
                    P_CHK: ph = (hval(draw_, daces) < 17) ? P_DD : P_RES;
                    default: begin
                        pv = hval(praw, paces);
                        dv = hval(draw_, daces);
                        if (pv > 21 || (dv <= 21 && pv < dv)) begin m_out = 2; m_l = sat_inc(m_l); end
                        else if (pv == dv)                    begin m_out = 3; m_p = sat_inc(m_p); end
                        else                                  begin m_out = 1; m_w = sat_inc(m_w); end
                        m_done = 1;
                        ph = P_IDLE;
                    end
                endcase
                m_req = (ph == P_DEAL || ph == P_PD || ph == P_DD);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("card_req", int'(bus.card_req), int'(m_req));
                chk("busy", int'(busy), int'(ph != P_IDLE));
                chk("round_done", int'(round_done), int'(m_done));
                chk("player_total", int'(player_total), hval(praw, paces));
                chk("dealer_total", int'(dealer_total), hval(draw_, daces));
                chk("outcome", int'(outcome), m_out);
                chk("wins", int'(wins), m_w);
                chk("losses", int'(losses), m_l);
                chk("pushes", int'(pushes), m_p);
            end
        end
    end

    // ---------------- card source ----------------
    initial begin
        bus.card_vld = 1'b0;
        bus.card_idx = 4'd0;
        forever begin
            @(posedge clk);
            if (bus.card_req && bus.card_vld && cq.size() > 0) void'(cq.pop_front());
            @(negedge clk);
            bus.card_vld = (cq.size() > 0);
            bus.card_idx = (cq.size() > 0) ? 4'(cq[0]) : 4'd0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int which);
        @(negedge clk);
        case (which)
            0: start = 1'b1;
            1: hit   = 1'b1;
            2: stay  = 1'b1;
            default: begin hit = 1'b1; stay = 1'b1; end
        endcase
        @(negedge clk);
        start = 1'b0; hit = 1'b0; stay = 1'b0;
    endtask

    task automatic idle_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!round_done && n < 60);
        chk(nm, int'(round_done), 1);
    endtask

    task automatic play_win_round();
        cq.push_back(9); cq.push_back(9); cq.push_back(9); cq.push_back(7);
        press(0); idle_cyc(8); press(2);
        wait_done("sat_done");
    endtask

    initial begin
        btnR = 1'b1; start = 1'b0; hit = 1'b0; stay = 1'b0;
        @(negedge clk);
        cmp_en = 1;
        chk("rst_card_req", int'(bus.card_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outcome", int'(outcome), 0);
        chk("rst_player", int'(player_total), 0);
        btnR = 1'b0;

        // Round 1: player 9+K=19, dealer 5+7+6=18 stands -> win
        cq.push_back(8); cq.push_back(4); cq.push_back(12); cq.push_back(6); cq.push_back(5);
        press(0); idle_cyc(8);
        chk("r1_wait_player", int'(player_total), 19);
        press(2);
        wait_done("r1_done");
        chk("r1_player", int'(player_total), 19);
        chk("r1_dealer", int'(dealer_total), 18);
        chk("r1_outcome", int'(outcome), 1);
        chk("r1_wins", int'(wins), 1);
        @(negedge clk);
        chk("r1_done_pulse", int'(round_done), 0);

        // Round 2: player A,A soft 12, hit 9 -> 21 auto-advance; dealer 10+7=17 -> win
        cq.push_back(0); cq.push_back(9); cq.push_back(0); cq.push_back(8); cq.push_back(6);
        press(0); idle_cyc(8);
        chk("r2_soft12", int'(player_total), 12);
        press(1);
        wait_done("r2_done");
        chk("r2_player", int'(player_total), 21);
        chk("r2_dealer", int'(dealer_total), 17);
        chk("r2_outcome", int'(outcome), 1);
        chk("r2_wins", int'(wins), 2);

        // Round 3: player 10+6, hit K -> 26 bust, dealer stays at 5 -> loss
        cq.push_back(9); cq.push_back(4); cq.push_back(5); cq.push_back(12);
        press(0); idle_cyc(8); press(1);
        wait_done("r3_done");
        chk("r3_player", int'(player_total), 26);
        chk("r3_dealer", int'(dealer_total), 5);
        chk("r3_outcome", int'(outcome), 2);
        chk("r3_losses", int'(losses), 1);
        idle_cyc(4);
        chk("r3_no_req", int'(bus.card_req), 0);

        // Round 4: player 10+7, hit+stay together acts as stay; dealer A+6 soft 17 -> push
        cq.push_back(9); cq.push_back(0); cq.push_back(6); cq.push_back(5);
        press(0); idle_cyc(8); press(3);
        wait_done("r4_done");
        chk("r4_player", int'(player_total), 17);
        chk("r4_dealer", int'(dealer_total), 17);
        chk("r4_outcome", int'(outcome), 3);
        chk("r4_pushes", int'(pushes), 1);

        // Round 5: card_vld withheld during DEAL_D1, then reset in PLAYER_WAIT
        cq.push_back(9);
        press(0); idle_cyc(6);
        chk("r5_hold_req", int'(bus.card_req), 1);
        chk("r5_hold_busy", int'(busy), 1);
        chk("r5_hold_player", int'(player_total), 10);
        chk("r5_hold_dealer", int'(dealer_total), 0);
        cq.push_back(7); cq.push_back(5);
        idle_cyc(6);
        chk("r5_wait_player", int'(player_total), 16);
        chk("r5_wait_req", int'(bus.card_req), 0);
        @(negedge clk); btnR = 1'b1;
        @(negedge clk); btnR = 1'b0;
        chk("r5_rst_player", int'(player_total), 0);
        chk("r5_rst_dealer", int'(dealer_total), 0);
        chk("r5_rst_busy", int'(busy), 0);
        chk("r5_rst_wins", int'(wins), 0);
        chk("r5_rst_losses", int'(losses), 0);
        chk("r5_rst_pushes", int'(pushes), 0);

        // Saturation: four wins with a 2-bit counter
        for (int i = 0; i < 3; i++) play_win_round();
        chk("sat_wins3", int'(wins), 3);
        play_win_round();
        chk("sat_wins4", int'(wins), 3);
        chk("sat_outcome", int'(outcome), 1);
        idle_cyc(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
